// File: rtl/line_follow_ctrl.sv
// Line-follow rover motor controller: debounced sensor inputs, follow/lost/search/blocked/halt
// state machine and per-mode PWM enables for a two-motor H-bridge.

module lfc_debounce #(
  parameter int W        = 1,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] filt_o
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [W-1:0]  sync1_q, sync2_q, prev_q, filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d, run_len;

  // run_len counts consecutive identical synchronised samples that differ from the filtered value
  always_comb begin
    // NOTE: every comb output gets a default first so no path can leave it unassigned (no latch).
    filt_d  = filt_q;
    run_len = (sync2_q != prev_q) ? CW'(1) : cnt_q + CW'(1);
    cnt_d   = run_len;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (run_len == CW'(DEBOUNCE)) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all flops sample pre-edge values together.
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      filt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;
endmodule

module line_follow_ctrl #(
  parameter int N_SENS       = 5,
  parameter int PWM_W        = 8,
  parameter int DEBOUNCE     = 4,
  parameter int LOST_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SENS-1:0] induct,
  input  logic              proxim,
  input  logic              red,
  input  logic              go,
  input  logic [PWM_W-1:0]  duty_fwd,
  input  logic [PWM_W-1:0]  duty_turn,
  output logic [3:0]        motorIn,
  output logic [1:0]        motorEn,
  output logic [2:0]        state
);
  localparam int C  = N_SENS / 2;
  localparam int TW = $clog2(LOST_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FOLLOW = 3'd1, S_LOST = 3'd2,
    S_SEARCH = 3'd3, S_BLOCKED = 3'd4, S_HALT = 3'd5
  } state_e;
  typedef enum logic {SIDE_LEFT = 1'b0, SIDE_RIGHT = 1'b1} side_e;

  localparam logic [3:0] M_STOP    = 4'b0000;
  localparam logic [3:0] M_FWD     = 4'b0101;
  localparam logic [3:0] M_STEER_L = 4'b0001;
  localparam logic [3:0] M_STEER_R = 4'b0100;
  localparam logic [3:0] M_PIVOT_L = 4'b1001;
  localparam logic [3:0] M_PIVOT_R = 4'b0110;
  localparam logic [N_SENS-1:0] ONLY_LEFT  = N_SENS'(1);
  localparam logic [N_SENS-1:0] ONLY_RIGHT = N_SENS'(1) << (N_SENS - 1);

  logic [N_SENS-1:0] induct_f;
  logic              proxim_f, red_f;
  logic              lf, rf, none;
  logic [3:0]        fol_motor;
  logic              fol_turn;

  state_e            state_q, state_d;
  side_e             last_side_q, last_side_d;
  logic [TW-1:0]     lost_cnt_q, lost_cnt_d;
  logic [3:0]        motor_q, motor_d;
  logic              turn_q, turn_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
  logic [1:0]        en_q, en_d;

  lfc_debounce #(.W(N_SENS), .DEBOUNCE(DEBOUNCE)) u_db_induct (
    .clk(clk), .rst_n(rst_n), .raw_i(induct), .filt_o(induct_f));
  lfc_debounce #(.W(1), .DEBOUNCE(DEBOUNCE)) u_db_proxim (
    .clk(clk), .rst_n(rst_n), .raw_i(proxim), .filt_o(proxim_f));
  lfc_debounce #(.W(1), .DEBOUNCE(DEBOUNCE)) u_db_red (
    .clk(clk), .rst_n(rst_n), .raw_i(red), .filt_o(red_f));

  assign lf   = |induct_f[C-1:0];
  assign rf   = |induct_f[N_SENS-1:C+1];
  assign none = ~|induct_f;

  // Pivots are the most specific patterns; centre-only and both-sides fall through to forward.
  always_comb begin
    fol_motor   = M_FWD;
    fol_turn    = 1'b0;
    last_side_d = last_side_q;
    if (induct_f == ONLY_LEFT) begin
      fol_motor = M_PIVOT_L;
      fol_turn  = 1'b1;
    end else if (induct_f == ONLY_RIGHT) begin
      fol_motor = M_PIVOT_R;
      fol_turn  = 1'b1;
    end else if (lf && !rf) begin
      fol_motor = M_STEER_L;
      fol_turn  = 1'b1;
    end else if (rf && !lf) begin
      fol_motor = M_STEER_R;
      fol_turn  = 1'b1;
    end
    if (lf && !rf)      last_side_d = SIDE_LEFT;
    else if (rf && !lf) last_side_d = SIDE_RIGHT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_side_q <= SIDE_LEFT;
      lost_cnt_q  <= '0;
      motor_q     <= M_STOP;
      turn_q      <= 1'b0;
      pwm_cnt_q   <= '0;
      duty_q      <= '0;
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      last_side_q <= last_side_d;
      lost_cnt_q  <= lost_cnt_d;
      motor_q     <= motor_d;
      turn_q      <= turn_d;
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      en_q        <= en_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lost_cnt_d = lost_cnt_q;
    case (state_q)
      S_IDLE: if (go) state_d = S_FOLLOW;
      S_HALT: if (go && !red_f) state_d = proxim_f ? S_BLOCKED : S_FOLLOW;
      default: begin
        if (red_f) begin
          state_d = S_HALT;
        end else if (proxim_f) begin
          state_d = S_BLOCKED;
        end else begin
          case (state_q)
            S_FOLLOW: if (none) begin
              state_d    = S_LOST;
              lost_cnt_d = '0;
            end
            S_LOST: begin
              if (!none)                                     state_d = S_FOLLOW;
              else if (lost_cnt_q == TW'(LOST_TIMEOUT - 1))  state_d = S_SEARCH;
              else                                           lost_cnt_d = lost_cnt_q + TW'(1);
            end
            S_SEARCH:  if (!none) state_d = S_FOLLOW;
            S_BLOCKED: state_d = S_FOLLOW;
            default:   state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // Outputs are computed from the next state so motorIn changes on the same edge as state.
  always_comb begin
    motor_d = motor_q;
    turn_d  = turn_q;
    case (state_d)
      S_FOLLOW: if (!none) begin
        motor_d = fol_motor;
        turn_d  = fol_turn;
      end
      S_LOST:   motor_d = motor_q;
      S_SEARCH: begin
        motor_d = (last_side_q == SIDE_RIGHT) ? M_PIVOT_R : M_PIVOT_L;
        turn_d  = 1'b1;
      end
      default:  motor_d = M_STOP;
    endcase
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    duty_d    = (&pwm_cnt_q) ? (turn_d ? duty_turn : duty_fwd) : duty_q;
    en_d[1]   = (pwm_cnt_d < duty_d) && (motor_d[3:2] != 2'b00);
    en_d[0]   = (pwm_cnt_d < duty_d) && (motor_d[1:0] != 2'b00);
  end

  assign motorIn = motor_q;
  assign motorEn = en_q;
  assign state   = state_q;
endmodule

// File: doc/line_follow_ctrl.md
# line_follow_ctrl

Parametrised, clocked successor to the combinational line-follow motor block: reads an N-wide inductive sensor bar, the proximity sensor and the red stop-marker input, and drives the two-motor H-bridge direction bits and PWM enables. It adds input debouncing, a recovery state machine for line loss and obstacles, and per-mode PWM duty control. It sits between the sensor front-end and the H-bridge pins at the top of the rover design.

## Interface
- N_SENS, 5, inductive sensor count; odd, ≥3; bit 0 leftmost, centre bit C = N_SENS/2
- PWM_W, 8, PWM counter and duty width
- DEBOUNCE, 4, consecutive stable cycles required before a filtered input updates (≥1)
- LOST_TIMEOUT, 1000, cycles the last command is held after line loss before searching (≥1)

- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- induct  in  N_SENS  raw sensor bar, 1 = line under sensor
- proxim  in  1  raw obstacle detect, 1 = obstacle
- red  in  1  raw stop-marker detect, 1 = marker
- go  in  1  start/resume request, level-sampled
- duty_fwd  in  PWM_W  duty used for straight driving
- duty_turn  in  PWM_W  duty used for steer/pivot/search
- motorIn  out  4  [3:2] left motor, [1:0] right motor; 01 fwd, 10 rev, 00 stop
- motorEn  out  2  [1] left, [0] right PWM enable
- state  out  3  current FSM state

## Operation
- Input path: induct, proxim, red each pass a 2-flop synchroniser, then a stability counter; filtered value takes the synchronised value once it has been identical for DEBOUNCE consecutive cycles. induct is filtered as a whole vector.
- Derived (filtered induct): Lf = any bit below C set; Rf = any bit above C set; Cf = bit C; none = all zero.
- Steering decode in FOLLOW: (Cf & !Lf & !Rf) or (Lf & Rf) → 0101, duty_fwd. Lf only (Cf don't-care) → 0001 steer left, duty_turn. Rf only → 0100 steer right, duty_turn. Only bit 0 set → 1001 pivot left; only bit N_SENS-1 set → 0110 pivot right; both at duty_turn.
- last_side register: set to LEFT when Lf & !Rf, RIGHT when Rf & !Lf, unchanged otherwise; reset LEFT.
- States: IDLE=0, FOLLOW=1, LOST=2, SEARCH=3, BLOCKED=4, HALT=5.
- Priority each cycle (outside IDLE): filtered red → HALT; else filtered proxim → BLOCKED; else line rules.
- IDLE: motorIn 0000, motorEn 00; go=1 → FOLLOW.
- FOLLOW: decode above; none → LOST, timeout counter cleared.
- LOST: hold last motorIn and duty; any sensor set → FOLLOW; counter reaches LOST_TIMEOUT → SEARCH.
- SEARCH: pivot toward last_side (LEFT 1001, RIGHT 0110), duty_turn; any sensor set → FOLLOW. No timeout.
- BLOCKED: motorIn 0000, motorEn 00; filtered proxim low → FOLLOW (falls to LOST next cycle if no line).
- HALT: motorIn 0000, motorEn 00, latched; go=1 with filtered red low → FOLLOW; go with red high stays HALT.
- go ignored outside IDLE/HALT.
- PWM: free-running PWM_W-bit counter, wraps max → 0. Active duty is loaded from duty_fwd/duty_turn only at wrap (cnt = max). motorEn bit = 1 when cnt < active duty and motor code ≠ 00; duty 0 → constant 0; duty max → high 2^PWM_W−1 of 2^PWM_W cycles.

## Timing
- Reset (rst_n low at clk edge): motorIn 0000, motorEn 00, state IDLE, PWM counter 0, active duty 0, filters 0, timeout counter 0, last_side LEFT. Reset mid-operation behaves identically on the next edge.
- Latency: raw input stable from edge t → filtered value at edge t+2+DEBOUNCE → state/motorIn updated at edge t+3+DEBOUNCE.
- Pulses shorter than DEBOUNCE cycles (after sync) never reach the filtered value.
- go: sampled at edge; IDLE→FOLLOW at the edge go is seen high; motorIn valid same edge.
- LOST→SEARCH exactly LOST_TIMEOUT cycles after LOST entry if no line returns; line returning on the expiry cycle → FOLLOW.
- Duty change takes effect at next wrap; mode change within a period keeps the old duty until wrap.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset, go=1, induct=00100, duty_fwd=128 → after 3+DEBOUNCE edges state=1, motorIn=0101, motorEn=11 for 128 of every 256 cycles.
- induct=00010 (Rf) → motorIn=0100; then induct=10000 only → 1001 pivot left; duty_turn=64 gives 64/256 enable.
- Line 01000 then 00000 → LOST holding 0001 for 1000 cycles, then SEARCH 1001; induct=00100 → FOLLOW 0101.
- proxim pulse of DEBOUNCE−1 cycles → no state change; held DEBOUNCE cycles → BLOCKED, motorEn=00; release → FOLLOW.
- red and proxim high together → HALT (state=5); go with red high stays HALT; red low then go → FOLLOW.
- rst_n low during SEARCH → next edge all outputs reset, state=0, motorEn=00.
